// File: rtl/rdy_vld_pkg.sv
// Shared types for the rdy_vld_skid register slice: FSM state encoding and
// the width of the held-beat count.
package rdy_vld_pkg;

  localparam int OCC_W = 2;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  // Number of beats held in a given state.
  function automatic logic [OCC_W-1:0] occ_of(input state_e st);
    case (st)
      ST_BUSY: occ_of = OCC_W'(1);
      ST_FULL: occ_of = OCC_W'(2);
      default: occ_of = OCC_W'(0);
    endcase
  endfunction

endpackage

// File: rtl/rdy_vld_skid.sv
// Skid-buffer register slice: valid, data and ready are all registered, so
// no input reaches any output combinationally.
module rdy_vld_skid
  import rdy_vld_pkg::*;
#(
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vld_in,
  input  logic [DWIDTH-1:0] din,
  output logic              rdy_out,
  output logic              vld_out,
  output logic [DWIDTH-1:0] dout,
  input  logic              rdy_in,
  output logic [OCC_W-1:0]  occ
);

  // Handshake: a beat moves on a port in any cycle where that port's valid and
  // ready are both high at the rising edge; valid/data never depend on ready.

  state_e            state_q, state_d;
  logic [DWIDTH-1:0] main_q, main_d;
  logic [DWIDTH-1:0] skid_q, skid_d;
  logic              rdy_q, rdy_d;
  logic              vld_q, vld_d;
  logic [OCC_W-1:0]  occ_q, occ_d;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (vld_in) begin
          main_d  = din;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (vld_in && rdy_in) begin
          main_d = din;
        end else if (vld_in) begin
          skid_d  = din;
          state_d = ST_FULL;
        end else if (rdy_in) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // Upstream sees rdy_out=0 here, so vld_in is not looked at.
        if (rdy_in) begin
          main_d  = skid_q;
          state_d = ST_BUSY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Output flops are loaded from the next state so they always match state_q.
    rdy_d = (state_d != ST_FULL);
    vld_d = (state_d != ST_EMPTY);
    occ_d = occ_of(state_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      rdy_q   <= 1'b1;
      vld_q   <= 1'b0;
      occ_q   <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      rdy_q   <= rdy_d;
      vld_q   <= vld_d;
      occ_q   <= occ_d;
    end
  end

  assign rdy_out = rdy_q;
  assign vld_out = vld_q;
  assign dout    = main_q;
  assign occ     = occ_q;

endmodule

// File: tb/tb_rdy_vld_skid.sv
// Bench for rdy_vld_skid: directed scenarios followed by random traffic, all
// checked against a two-entry FIFO reference model.
module tb_rdy_vld_skid;

  localparam int W = 32;
  localparam int N_BEATS = 10000;
  localparam int RAND_BUDGET = 40000;

  logic         clk = 1'b0;
  logic         rst;
  logic         vld_in;
  logic [W-1:0] din;
  logic         rdy_out;
  logic         vld_out;
  logic [W-1:0] dout;
  logic         rdy_in;
  logic [1:0]   occ;

  int tests    = 0;
  int failed   = 0;
  int sent     = 0;
  int dut_recv = 0;

  // Reference model: the beats the slice is holding, oldest first.
  logic [W-1:0] exp_q[$];

  rdy_vld_skid #(.DWIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .vld_in  (vld_in),
    .din     (din),
    .rdy_out (rdy_out),
    .vld_out (vld_out),
    .dout    (dout),
    .rdy_in  (rdy_in),
    .occ     (occ)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    check("vld_out", W'(vld_out), W'(exp_q.size() != 0));
    check("rdy_out", W'(rdy_out), W'(exp_q.size() < 2));
    check("occ", W'(occ), W'(exp_q.size()));
    if (exp_q.size() != 0) check("dout", dout, exp_q[0]);
  endtask

  // One clock: check outputs at the falling edge, drive inputs, then apply the
  // model's transfers at the rising edge. Returns just after the rising edge.
  task automatic cycle(input logic v, input logic [W-1:0] d, input logic r);
    bit pop;
    bit push;
    @(negedge clk);
    check_outputs();
    vld_in = v;
    din    = d;
    rdy_in = r;
    pop  = (exp_q.size() != 0) && r;
    push = v && (exp_q.size() < 2);
    if (vld_out && r) dut_recv++;
    @(posedge clk);
    if (pop) void'(exp_q.pop_front());
    if (push) begin
      exp_q.push_back(d);
      sent++;
    end
  endtask

  initial begin
    int cyc;
    rst = 1'b1; vld_in = 1'b0; din = '0; rdy_in = 1'b0;
    #3;
    check("reset_vld", W'(vld_out), W'(0));
    check("reset_rdy", W'(rdy_out), W'(1));
    check("reset_occ", W'(occ), W'(0));
    check("reset_dout", dout, W'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Streaming at full rate.
    for (int i = 1; i <= 4; i++) cycle(1'b1, W'(i), 1'b1);
    #1;
    check("stream_last_dout", dout, W'(4));
    check("stream_rdy", W'(rdy_out), W'(1));
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b1);

    // Stall fill, then offer a third beat while full.
    cycle(1'b1, W'('hA), 1'b0);
    cycle(1'b1, W'('hB), 1'b0);
    #1;
    check("fill_occ", W'(occ), W'(2));
    check("fill_rdy", W'(rdy_out), W'(0));
    check("fill_dout", dout, W'('hA));
    cycle(1'b1, W'('hC), 1'b0);
    #1;
    check("full_ignores_din", dout, W'('hA));
    check("full_occ", W'(occ), W'(2));

    // Drain over two cycles, then 0xC goes through.
    cycle(1'b0, '0, 1'b1);
    #1;
    check("drain1_dout", dout, W'('hB));
    check("drain1_occ", W'(occ), W'(1));
    check("drain1_rdy", W'(rdy_out), W'(1));
    cycle(1'b0, '0, 1'b1);
    #1;
    check("drain2_occ", W'(occ), W'(0));
    cycle(1'b1, W'('hC), 1'b0);
    #1;
    check("late_c_dout", dout, W'('hC));
    cycle(1'b0, '0, 1'b1);

    // Simultaneous accept and release in BUSY.
    cycle(1'b1, W'(5), 1'b0);
    cycle(1'b1, W'(6), 1'b1);
    #1;
    check("simul_dout", dout, W'(6));
    check("simul_occ", W'(occ), W'(1));
    cycle(1'b0, '0, 1'b1);

    // Asynchronous reset while FULL.
    cycle(1'b1, W'(7), 1'b0);
    cycle(1'b1, W'(8), 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("areset_vld", W'(vld_out), W'(0));
    check("areset_rdy", W'(rdy_out), W'(1));
    check("areset_occ", W'(occ), W'(0));
    check("areset_dout", dout, W'(0));
    exp_q.delete();
    @(posedge clk);
    #2;
    rst = 1'b0;
    cycle(1'b1, W'(9), 1'b1);
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b0);

    // Random traffic.
    sent = 0;
    dut_recv = 0;
    cyc = 0;
    while (sent < N_BEATS && cyc < RAND_BUDGET) begin
      cycle($urandom_range(0, 3) != 0, W'($urandom), $urandom_range(0, 3) != 0);
      cyc++;
    end
    check("random_beats_sent", W'(sent >= N_BEATS), W'(1));
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1);
    #1;
    check("random_drained_occ", W'(occ), W'(0));
    check("random_recv_count", W'(dut_recv), W'(sent));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/rdy_vld_skid.md
RDY_VLD_SKID -- requirements
Module: rdy_vld_skid

Interface
REQ-001 SHALL have parameter DWIDTH, default 32, data width of din, dout and the internal registers.
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port vld_in  input  1  upstream valid.
REQ-005 SHALL have port din  input  DWIDTH  upstream data.
REQ-006 SHALL have port rdy_out  output  1  upstream ready, driven directly from a flop.
REQ-007 SHALL have port vld_out  output  1  downstream valid, driven directly from a flop.
REQ-008 SHALL have port dout  output  DWIDTH  downstream data, driven directly from a flop.
REQ-009 SHALL have port rdy_in  input  1  downstream ready.
REQ-010 SHALL have port occ  output  2  held-beat count (0, 1 or 2), driven from state.

Function
REQ-011 SHALL be a skid-buffer register slice that cuts the ready path as well as the valid and data paths; there SHALL be no combinational path from any input to any output.
REQ-012 SHALL transfer a beat upstream when vld_in & rdy_out in a cycle, and downstream when vld_out & rdy_in in a cycle.
REQ-013 SHALL hold two data registers: main (drives dout) and skid, plus a 3-state FSM EMPTY/BUSY/FULL.
REQ-014 EMPTY: rdy_out=1, vld_out=0, occ=0; on vld_in, load main <= din and go to BUSY; otherwise stay.
REQ-015 BUSY: rdy_out=1, vld_out=1, occ=1; on vld_in & rdy_in, load main <= din and stay; on vld_in & !rdy_in, load skid <= din and go to FULL; on !vld_in & rdy_in, go to EMPTY; otherwise hold.
REQ-016 FULL: rdy_out=0, vld_out=1, occ=2; vld_in SHALL be ignored; on rdy_in, load main <= skid and go to BUSY; otherwise hold.
REQ-017 SHALL make the upstream-to-downstream latency exactly 1 cycle when not stalled; a beat accepted at edge N is visible on dout/vld_out after edge N.
REQ-018 SHALL sustain full throughput (one beat per cycle) when rdy_in is continuously high.
REQ-019 SHALL hold dout and vld_out stable while vld_out=1 and rdy_in=0.
REQ-020 SHALL neither drop nor duplicate beats, and SHALL preserve their order under any rdy_in/vld_in pattern.
REQ-021 SHALL allow rdy_in to toggle while vld_out=0 without effect.
REQ-022 SHALL keep the registered rdy_out, vld_out and occ consistent with the FSM state at all times.

Reset
REQ-023 While rst=1 the block SHALL be in EMPTY with rdy_out=1, vld_out=0, occ=0, and main and skid set to 0; this takes effect asynchronously.
REQ-024 A reset in BUSY or FULL SHALL discard all held beats; the first cycle after release SHALL accept a new beat.

Structure
REQ-025 The FSM state enum typedef (EMPTY/BUSY/FULL) and the occupancy width constant SHALL live in the shared package rdy_vld_pkg.
REQ-026 SHALL have no sub-module; the FSM and both data registers are inline in rdy_vld_skid.

Verification
REQ-027 Streaming: rdy_in=1, din=1,2,3,4 on 4 consecutive cycles with vld_in=1 -> dout=1,2,3,4 one cycle later each, vld_out high for 4 cycles, rdy_out stays 1.
REQ-028 Stall fill: rdy_in=0, send 0xA then 0xB -> occ=2, rdy_out=0 after 2nd edge, dout=0xA held; 0xC offered while FULL -> not accepted.
REQ-029 Drain: from REQ-028 state raise rdy_in for 2 cycles -> dout=0xA then 0xB, occ goes 2->1->0, rdy_out=1 after 1st drain edge; 0xC accepted only after rdy_out=1.
REQ-030 Simultaneous: in BUSY with dout=0x5, vld_in=1 din=0x6 and rdy_in=1 -> stays BUSY, dout=0x6, occ=1.
REQ-031 Reset mid-op: in FULL, assert rst asynchronously between edges -> vld_out=0, rdy_out=1, occ=0, dout=0 immediately; no stale beat after release.
REQ-032 Random: random vld_in/rdy_in with a scoreboard over 10000 beats -> no loss, no duplication, order preserved, and dout stable during stalls.
